// File: rtl/mem_access_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_access_pkg : shared types and defaults for the memory sequencer |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package mem_access_pkg;

   localparam int unsigned WORD_W = 16;

   localparam logic [WORD_W-1:0] DEF_RESET_PC = 16'h0000;
   localparam logic [WORD_W-1:0] DEF_PC_STEP  = 16'h0001;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      LOAD  = 2'd2,
      STORE = 2'd3
   } state_e;

endpackage
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pc_unit : program counter with synchronous reset, load and step    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module pc_unit
   import mem_access_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC = DEF_RESET_PC,
   parameter logic [WORD_W-1:0] PC_STEP  = DEF_PC_STEP
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load_i,
   input  logic [WORD_W-1:0] target_i,
   input  logic              inc_i,
   output logic [WORD_W-1:0] pc_o
);

   logic [WORD_W-1:0] pc_q;
   logic [WORD_W-1:0] pc_d;

   // A branch outranks the post-fetch increment.
   always_comb begin
      pc_d = pc_q;
      if (load_i) begin
         pc_d = target_i;
      end else if (inc_i) begin
         pc_d = pc_q + PC_STEP;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_access_ctrl : serialises fetches and loads/stores onto one RAM  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module mem_access_ctrl
   import mem_access_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC = DEF_RESET_PC,
   parameter logic [WORD_W-1:0] PC_STEP  = DEF_PC_STEP
) (
   input  logic              I_clk,
   input  logic              I_rst,
   input  logic              I_fetch_req,
   input  logic              I_pc_load,
   input  logic [WORD_W-1:0] I_pc_target,
   input  logic              I_ls_req,
   input  logic              I_ls_we,
   input  logic [WORD_W-1:0] I_ls_addr,
   input  logic [WORD_W-1:0] I_ls_data,
   input  logic [WORD_W-1:0] I_ram_rdata,
   output logic [WORD_W-1:0] O_ram_addr,
   output logic              O_ram_we,
   output logic [WORD_W-1:0] O_ram_wdata,
   output logic [WORD_W-1:0] O_pc,
   output logic [WORD_W-1:0] O_instr,
   output logic              O_instr_valid,
   output logic [WORD_W-1:0] O_ls_rdata,
   output logic              O_ls_done,
   output logic              O_busy
);

   state_e            state_q, state_d;
   logic [WORD_W-1:0] ram_addr_q, ram_addr_d;
   logic              ram_we_q, ram_we_d;
   logic [WORD_W-1:0] ram_wdata_q, ram_wdata_d;
   logic [WORD_W-1:0] instr_q, instr_d;
   logic              instr_valid_q, instr_valid_d;
   logic [WORD_W-1:0] ls_rdata_q, ls_rdata_d;
   logic              ls_done_q, ls_done_d;
   logic              pc_inc;
   logic [WORD_W-1:0] pc;

   pc_unit #(
      .RESET_PC (RESET_PC),
      .PC_STEP  (PC_STEP)
   ) u_pc_unit (
      .clk_i    (I_clk),
      .rst_i    (I_rst),
      .load_i   (I_pc_load),
      .target_i (I_pc_target),
      .inc_i    (pc_inc),
      .pc_o     (pc)
   );

   always_comb begin
      state_d       = state_q;
      ram_addr_d    = ram_addr_q;
      ram_we_d      = 1'b0;
      ram_wdata_d   = ram_wdata_q;
      instr_d       = instr_q;
      instr_valid_d = 1'b0;
      ls_rdata_d    = ls_rdata_q;
      ls_done_d     = 1'b0;
      pc_inc        = 1'b0;

      case (state_q)
         IDLE: begin
            // A PC load in IDLE consumes the cycle; no access is started.
            if (!I_pc_load) begin
               if (I_ls_req) begin
                  ram_addr_d = I_ls_addr;
                  if (I_ls_we) begin
                     state_d     = STORE;
                     ram_wdata_d = I_ls_data;
                     ram_we_d    = 1'b1;
                  end else begin
                     state_d = LOAD;
                  end
               end else if (I_fetch_req) begin
                  state_d    = FETCH;
                  ram_addr_d = pc;
               end
            end
         end
         FETCH: begin
            state_d = IDLE;
            if (!I_pc_load) begin
               instr_d       = I_ram_rdata;
               instr_valid_d = 1'b1;
               pc_inc        = 1'b1;
            end
         end
         LOAD: begin
            state_d    = IDLE;
            ls_rdata_d = I_ram_rdata;
            ls_done_d  = 1'b1;
         end
         STORE: begin
            state_d   = IDLE;
            ls_done_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         state_q       <= IDLE;
         ram_addr_q    <= RESET_PC;
         ram_we_q      <= 1'b0;
         ram_wdata_q   <= '0;
         instr_q       <= '0;
         instr_valid_q <= 1'b0;
         ls_rdata_q    <= '0;
         ls_done_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         ram_addr_q    <= ram_addr_d;
         ram_we_q      <= ram_we_d;
         ram_wdata_q   <= ram_wdata_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
         ls_rdata_q    <= ls_rdata_d;
         ls_done_q     <= ls_done_d;
      end
   end

   assign O_ram_addr    = ram_addr_q;
   assign O_ram_we      = ram_we_q;
   assign O_ram_wdata   = ram_wdata_q;
   assign O_pc          = pc;
   assign O_instr       = instr_q;
   assign O_instr_valid = instr_valid_q;
   assign O_ls_rdata    = ls_rdata_q;
   assign O_ls_done     = ls_done_q;
   assign O_busy        = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mem_access_ctrl : directed plus random bench with a RAM model    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_mem_access_ctrl;
   import mem_access_pkg::*;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, fetch_req, pc_load, ls_req, ls_we;
   logic [15:0] pc_target, ls_addr, ls_data, ram_rdata;
   wire  [15:0] ram_addr, ram_wdata, pc, instr, ls_rdata;
   wire         ram_we, instr_valid, ls_done, busy;

   logic        wrap_fetch;
   wire  [15:0] w_ram_addr, w_ram_wdata, w_pc, w_instr, w_ls_rdata;
   wire         w_ram_we, w_instr_valid, w_ls_done, w_busy;

   mem_access_ctrl u_dut (
      .I_clk(clk), .I_rst(rst), .I_fetch_req(fetch_req), .I_pc_load(pc_load),
      .I_pc_target(pc_target), .I_ls_req(ls_req), .I_ls_we(ls_we),
      .I_ls_addr(ls_addr), .I_ls_data(ls_data), .I_ram_rdata(ram_rdata),
      .O_ram_addr(ram_addr), .O_ram_we(ram_we), .O_ram_wdata(ram_wdata),
      .O_pc(pc), .O_instr(instr), .O_instr_valid(instr_valid),
      .O_ls_rdata(ls_rdata), .O_ls_done(ls_done), .O_busy(busy)
   );

   mem_access_ctrl #(.RESET_PC(16'hFFFF)) u_wrap (
      .I_clk(clk), .I_rst(rst), .I_fetch_req(wrap_fetch), .I_pc_load(1'b0),
      .I_pc_target(16'h0000), .I_ls_req(1'b0), .I_ls_we(1'b0),
      .I_ls_addr(16'h0000), .I_ls_data(16'h0000), .I_ram_rdata(16'h0000),
      .O_ram_addr(w_ram_addr), .O_ram_we(w_ram_we), .O_ram_wdata(w_ram_wdata),
      .O_pc(w_pc), .O_instr(w_instr), .O_instr_valid(w_instr_valid),
      .O_ls_rdata(w_ls_rdata), .O_ls_done(w_ls_done), .O_busy(w_busy)
   );

   // Environment RAM: samples address/we and refreshes read data on the falling edge.
   logic [15:0] ram  [0:65535];
   logic [15:0] mmem [0:65535];
   always @(negedge clk) begin
      if (ram_we) ram[ram_addr] = ram_wdata;
      ram_rdata <= ram[ram_addr];
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, act, exp);
   endtask

   // Transaction-level reference: at most one outstanding access, which ends one edge after it starts.
   localparam int K_NONE = 0, K_FETCH = 1, K_LOAD = 2, K_STORE = 3;
   int          m_kind;
   logic [15:0] m_addr, m_wdata, m_pc, m_instr, m_ls_rdata;
   logic        m_valid, m_done, m_we;

   task automatic model_reset();
      m_kind = K_NONE; m_addr = 16'h0000; m_wdata = 16'h0000; m_pc = 16'h0000;
      m_instr = 16'h0000; m_ls_rdata = 16'h0000; m_valid = 0; m_done = 0; m_we = 0;
   endtask

   task automatic model_edge();
      if (rst) begin
         model_reset();
         return;
      end
      m_valid = 0; m_done = 0; m_we = 0;
      if (m_kind != K_NONE) begin
         if (m_kind == K_FETCH && !pc_load) begin
            m_instr = mmem[m_addr];
            m_valid = 1;
            m_pc    = m_pc + 16'd1;
         end
         if (m_kind == K_LOAD) m_ls_rdata = mmem[m_addr];
         if (m_kind != K_FETCH) m_done = 1;
         if (pc_load) m_pc = pc_target;
         m_kind = K_NONE;
      end else if (pc_load) begin
         m_pc = pc_target;
      end else if (ls_req) begin
         m_addr = ls_addr;
         if (ls_we) begin
            m_kind = K_STORE; m_wdata = ls_data; m_we = 1;
            mmem[ls_addr] = ls_data;
         end else begin
            m_kind = K_LOAD;
         end
      end else if (fetch_req) begin
         m_kind = K_FETCH;
         m_addr = m_pc;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      chk("pc",          pc,          m_pc);
      chk("instr",       instr,       m_instr);
      chk("instr_valid", instr_valid, m_valid);
      chk("ls_rdata",    ls_rdata,    m_ls_rdata);
      chk("ls_done",     ls_done,     m_done);
      chk("busy",        busy,        m_kind != K_NONE);
      chk("ram_we",      ram_we,      m_we);
      chk("ram_addr",    ram_addr,    m_addr);
      chk("ram_wdata",   ram_wdata,   m_wdata);
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) ram[i] = 16'($urandom);
      ram[0] = 16'h80FE; ram[1] = 16'h89ED; ram[2] = 16'h2220;
      for (int i = 0; i < 65536; i++) mmem[i] = ram[i];
      model_reset();
      rst = 1; fetch_req = 0; pc_load = 0; ls_req = 0; ls_we = 0; wrap_fetch = 0;
      pc_target = 0; ls_addr = 0; ls_data = 0;
      #1;
      cycle(); cycle();
      chk("rst_pc", pc, 16'h0000);
      chk("rst_wrap_addr", w_ram_addr, 16'hFFFF);
      rst = 0;

      // Reset then fetch, with a single wrap-around fetch on the second instance
      fetch_req = 1; wrap_fetch = 1;
      cycle(); wrap_fetch = 0;
      cycle();
      chk("t1_instr0", instr, 16'h80FE);
      chk("t1_valid0", instr_valid, 1'b1);
      chk("wrap_pc", w_pc, 16'h0000);
      cycle(); cycle(); fetch_req = 0;
      chk("t1_instr1", instr, 16'h89ED);
      chk("t1_pc", pc, 16'h0002);

      // Store then load
      ls_req = 1; ls_we = 1; ls_addr = 16'd5; ls_data = 16'hBEEF;
      cycle(); ls_req = 0; ls_we = 0;
      chk("st_we", ram_we, 1'b1);
      cycle();
      chk("st_done", ls_done, 1'b1);
      ls_req = 1; ls_addr = 16'd5;
      cycle(); ls_req = 0;
      cycle();
      chk("ld_rdata", ls_rdata, 16'hBEEF);

      // Contention: load wins, fetch follows
      fetch_req = 1; ls_req = 1; ls_we = 0; ls_addr = 16'd2;
      cycle(); cycle(); ls_req = 0;
      chk("ct_rdata", ls_rdata, 16'h2220);
      chk("ct_pc", pc, 16'h0002);
      cycle(); cycle(); fetch_req = 0;
      chk("ct_instr", instr, 16'h2220);
      chk("ct_pc2", pc, 16'h0003);

      // Branch squash at the edge ending FETCH
      fetch_req = 1;
      cycle(); pc_load = 1; pc_target = 16'h0006;
      cycle(); pc_load = 0;
      chk("sq_valid", instr_valid, 1'b0);
      chk("sq_instr", instr, 16'h2220);
      chk("sq_pc", pc, 16'h0006);
      cycle();
      chk("sq_addr", ram_addr, 16'h0006);
      cycle(); fetch_req = 0;
      chk("sq_instr6", instr, ram[6]);

      // Reset at the edge ending a store; the RAM write still lands
      ls_req = 1; ls_we = 1; ls_addr = 16'd9; ls_data = 16'h1234;
      cycle(); ls_req = 0; ls_we = 0; rst = 1;
      cycle(); rst = 0;
      chk("rs_done", ls_done, 1'b0);
      chk("rs_busy", busy, 1'b0);
      chk("rs_pc", pc, 16'h0000);
      ls_req = 1; ls_addr = 16'd9;
      cycle(); ls_req = 0;
      cycle();
      chk("rs_rdata", ls_rdata, 16'h1234);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         rst       = ($urandom_range(0, 63) == 0);
         fetch_req = ($urandom_range(0, 2) != 0);
         pc_load   = ($urandom_range(0, 7) == 0);
         pc_target = 16'($urandom_range(0, 15));
         ls_req    = ($urandom_range(0, 2) == 0);
         ls_we     = 1'($urandom);
         ls_addr   = 16'($urandom_range(0, 15));
         ls_data   = 16'($urandom);
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Single-port memory sequencer sitting directly upstream of the 16-bit RAM: it owns the program counter, issues instruction fetches, and serialises load/store requests from the execute stage onto the one RAM port. The RAM samples address and write-enable and updates its read data on the falling clock edge. The controller drives all RAM inputs from rising-edge registers and captures read data on the following rising edge.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC and RAM address value after reset
- PC_STEP, 16'h0001, PC increment per completed fetch (word addressing)

Ports:
- I_clk  in  1  system clock; all state updates on the rising edge
- I_rst  in  1  reset, synchronous, active-high
- I_fetch_req  in  1  level request for the next instruction at O_pc
- I_pc_load  in  1  load I_pc_target into the PC (branch/jump)
- I_pc_target  in  16  new PC value
- I_ls_req  in  1  level request for a data access
- I_ls_we  in  1  1 = store, 0 = load; qualified by I_ls_req
- I_ls_addr  in  16  data address
- I_ls_data  in  16  store data
- I_ram_rdata  in  16  RAM read data
- O_ram_addr  out  16  RAM address
- O_ram_we  out  1  RAM write enable
- O_ram_wdata  out  16  RAM write data
- O_pc  out  16  current PC
- O_instr  out  16  last fetched instruction, held until next fetch
- O_instr_valid  out  1  one-cycle pulse: O_instr updated
- O_ls_rdata  out  16  last load result, held
- O_ls_done  out  1  one-cycle pulse: load or store complete
- O_busy  out  1  high while in FETCH, LOAD or STORE

## Operation
- FSM states: IDLE, FETCH, LOAD, STORE. All outputs are registered.
- In IDLE, priority is evaluated at each edge, highest first:
  - I_pc_load: PC becomes I_pc_target and no access starts.
  - I_ls_req: go to LOAD or STORE per I_ls_we, with O_ram_addr = I_ls_addr. For a store, O_ram_wdata = I_ls_data and O_ram_we = 1.
  - I_fetch_req: go to FETCH with O_ram_addr = PC.
  - Otherwise stay in IDLE.
- Leaving FETCH:
  - Capture I_ram_rdata into O_instr, pulse O_instr_valid, set PC += PC_STEP (mod 2^16; 16'hFFFF wraps to 16'h0000), go to IDLE.
  - If I_pc_load is sampled at this edge, the fetch is squashed: O_instr is unchanged, there is no valid pulse, PC = I_pc_target, go to IDLE.
- Leaving LOAD: capture I_ram_rdata into O_ls_rdata, pulse O_ls_done, go to IDLE.
- Leaving STORE: O_ram_we returns to 0, pulse O_ls_done, go to IDLE. O_ls_rdata is unchanged.
- I_pc_load sampled in LOAD or STORE updates the PC only; the access completes normally.
- IDLE is mandatory between accesses, so peak throughput is one access per 2 cycles.
- In IDLE, O_ram_addr holds the last driven address and O_ram_we = 0.
- Handshake: a requester holds its request until it sees its done/valid pulse. If the request is still high at the edge after the pulse, a new access starts.
- Request inputs change only on the rising edge; the RAM inputs are therefore stable across the falling edge.

## Timing
- Request sampled at rising edge k:
  - The access cycle runs from edge k to edge k+1; the RAM acts at the falling edge inside it.
  - Result and pulse are high from edge k+1 to edge k+2.
- O_ram_we is high for exactly one cycle per store. The RAM write occurs at the falling edge within that cycle.
- Reset values: state IDLE, O_pc = RESET_PC, O_ram_addr = RESET_PC, O_ram_we = 0, O_ram_wdata = 0, O_instr = 0, O_ls_rdata = 0, O_instr_valid = 0, O_ls_done = 0, O_busy = 0.
- Reset mid-access:
  - I_rst at the edge ending an access aborts it: no capture, no pulse, all outputs go to reset values.
  - A store whose falling edge has already passed has written the RAM; this is accepted.
- Simultaneous I_fetch_req and I_ls_req in IDLE: the load/store goes first. The fetch request, still held, is served after the next IDLE cycle.

## Structure
- Package mem_access_pkg holds:
  - the state enum (IDLE = 2'd0, FETCH = 2'd1, LOAD = 2'd2, STORE = 2'd3);
  - the 16-bit word width constant;
  - the default RESET_PC and PC_STEP values.
- Sub-module pc_unit: PC register with synchronous reset, load and increment. Load has priority over increment.

## Test plan
- Reset then fetch: RAM[0]=16'h80FE, RAM[1]=16'h89ED, I_fetch_req held high for 4 cycles -> O_instr = 16'h80FE with a valid pulse 2 edges after request, then 16'h89ED two cycles later; O_pc goes 0 -> 1 -> 2.
- Store then load: store 16'hBEEF to addr 5 -> exactly one O_ram_we cycle and an O_ls_done pulse; then load addr 5 -> O_ls_rdata = 16'hBEEF.
- Contention: I_fetch_req and I_ls_req (load addr 2, RAM[2]=16'h2220) raised together -> load completes first, fetch completes 2 cycles later; O_pc unchanged until the fetch.
- Branch squash: I_pc_load with target 16'h0006 at the edge ending FETCH -> no O_instr_valid pulse, O_instr unchanged, O_pc = 6; the next fetch reads addr 6.
- Wrap: RESET_PC = 16'hFFFF, one fetch -> O_pc = 16'h0000.
- Reset mid-store: I_rst at the edge ending STORE -> no O_ls_done pulse, all outputs at reset values the next cycle, FSM in IDLE.
